// File: rtl/descrambler_51bit_order49.sv
// Self-synchronising descrambler for 51-bit frames with taps at 40 and 49 bits back.
// The output is registered, and data_valid rises once PRIME_FRAMES frames of history have been absorbed.
module descrambler_51bit_order49 #(
  parameter logic [50:0] INIT_SEED    = 51'h7f1835baaca14,
  parameter int unsigned PRIME_FRAMES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        bypass,
  input  logic [50:0] data_in,
  output logic [50:0] data_out,
  output logic        data_valid
);

  // state | meaning
  // PRIME | history not yet trusted, counting enabled frames
  // RUN   | history primed, data_valid held high until reset
  typedef enum logic {PRIME, RUN} state_t;

  localparam logic [3:0] PRIME_LAST = 4'(PRIME_FRAMES - 1);

  state_t      state;
  logic [3:0]  prime_cnt;
  // Bits 0 and 1 of the previous frame are never tapped, so they are not stored.
  logic [50:2] hist;
  logic [50:0] d;

  for (genvar i = 0; i < 51; i++) begin : g_bit
    if (i < 40) begin : g_hist
      assign d[i] = data_in[i] ~^ hist[i+11] ~^ hist[i+2];
    end else if (i < 49) begin : g_mix
      assign d[i] = data_in[i] ~^ data_in[i-40] ~^ hist[i+2];
    end else begin : g_cur
      assign d[i] = data_in[i] ~^ data_in[i-40] ~^ data_in[i-49];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hist       <= INIT_SEED[50:2];
      data_out   <= '0;
      data_valid <= 1'b0;
      prime_cnt  <= '0;
      state      <= PRIME;
    end else if (enable) begin
      hist     <= data_in[50:2];
      data_out <= bypass ? data_in : d;
      case (state)
        PRIME: begin
          data_valid <= 1'b0;
          if (prime_cnt == PRIME_LAST) state <= RUN;
          if (prime_cnt != 4'hf) prime_cnt <= prime_cnt + 4'd1;
        end
        RUN: data_valid <= 1'b1;
        default: state <= PRIME;
      endcase
    end
  end

endmodule

// File: tb/tb_descrambler_51bit_order49.sv
// Randomised loopback bench: a bit-serial scrambler model feeds the descrambler.
// Outputs are compared against the original payload and against hand-derived error patterns.
module tb_descrambler_51bit_order49;
  localparam logic [50:0] SEED = 51'h7f1835baaca14;

  logic        clock = 1'b0;
  logic        reset, enable, bypass;
  logic [50:0] data_in;
  logic [50:0] data_out, data_out_z;
  logic        data_valid, data_valid_z;

  int checks = 0;
  int failures = 0;

  // tx_h[k-1] holds the scrambled bit sent k bit-times ago.
  logic [48:0] tx_h;

  descrambler_51bit_order49 dut (
    .clock(clock), .reset(reset), .enable(enable), .bypass(bypass),
    .data_in(data_in), .data_out(data_out), .data_valid(data_valid)
  );

  descrambler_51bit_order49 #(.INIT_SEED(51'h0)) dut_zero (
    .clock(clock), .reset(reset), .enable(enable), .bypass(bypass),
    .data_in(data_in), .data_out(data_out_z), .data_valid(data_valid_z)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tx_reset();
    for (int k = 1; k <= 49; k++) tx_h[k-1] = SEED[51-k];
  endtask

  task automatic tx_push(input logic [50:0] raw);
    for (int i = 0; i < 51; i++) tx_h = {tx_h[47:0], raw[i]};
  endtask

  task automatic scramble(input logic [50:0] d, output logic [50:0] s);
    for (int i = 0; i < 51; i++) begin
      s[i] = d[i] ~^ tx_h[39] ~^ tx_h[48];
      tx_h = {tx_h[47:0], s[i]};
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [50:0] rnd51();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[50:0];
  endfunction

  logic [50:0] d, s, held, ones, raw;

  initial begin
    ones = '1;
    reset = 1'b1; enable = 1'b1; bypass = 1'b0; data_in = rnd51();
    tick(); tick();
    check_val("reset_out", 64'(data_out), 64'h0);
    check_val("reset_valid", 64'(data_valid), 64'h0);
    reset = 1'b0;
    tx_reset();

    // Loopback from reset, with the zero-seeded copy re-synchronising.
    for (int n = 0; n < 1000; n++) begin
      d = rnd51();
      scramble(d, s);
      data_in = s;
      tick();
      check_val("loop_data", 64'(data_out), 64'(d));
      check_val("loop_valid", 64'(data_valid), (n >= 1) ? 64'h1 : 64'h0);
      if (n == 0) check_val("sync_first_differs", 64'(data_out_z != d), 64'h1);
      else        check_val("sync_data", 64'(data_out_z), 64'(d));
    end

    // Known vector: all-ones history, zero frame.
    data_in = ones; tick(); tx_push(ones);
    data_in = '0;   tick(); tx_push('0);
    check_val("known_vector", 64'(data_out), 64'h1ff0000000000);

    d = rnd51(); scramble(d, s); data_in = s; tick();
    check_val("resume_after_vector", 64'(data_out), 64'(d));

    // Enable low: outputs frozen, random inputs ignored.
    held = data_out;
    enable = 1'b0;
    for (int n = 0; n < 5; n++) begin
      data_in = rnd51();
      tick();
      check_val("hold_out", 64'(data_out), 64'(held));
      check_val("hold_valid", 64'(data_valid), 64'h1);
    end
    enable = 1'b1;
    for (int n = 0; n < 3; n++) begin
      d = rnd51(); scramble(d, s); data_in = s; tick();
      check_val("after_hold", 64'(data_out), 64'(d));
    end

    // Bypass: raw pass-through, history still absorbs the frame.
    bypass = 1'b1; data_in = 51'h1; tick(); tx_push(51'h1);
    check_val("bypass_out", 64'(data_out), 64'h1);
    check_val("bypass_valid", 64'(data_valid), 64'h1);
    bypass = 1'b0;
    for (int n = 0; n < 3; n++) begin
      d = rnd51(); scramble(d, s); data_in = s; tick();
      check_val("after_bypass", 64'(data_out), 64'(d));
    end

    // Single-bit error in bit 5: bits 5 and 45 of this frame, bit 3 of the next.
    d = rnd51(); scramble(d, s); data_in = s ^ (51'h1 << 5); tick();
    check_val("err_frame", 64'(data_out ^ d), 64'((51'h1 << 5) | (51'h1 << 45)));
    d = rnd51(); scramble(d, s); data_in = s; tick();
    check_val("err_next", 64'(data_out ^ d), 64'(51'h1 << 3));
    d = rnd51(); scramble(d, s); data_in = s; tick();
    check_val("err_clear", 64'(data_out), 64'(d));

    // Mid-stream reset with the transmitter reset as well.
    reset = 1'b1; data_in = rnd51(); tick();
    check_val("midreset_out", 64'(data_out), 64'h0);
    check_val("midreset_valid", 64'(data_valid), 64'h0);
    reset = 1'b0;
    tx_reset();
    for (int n = 0; n < 4; n++) begin
      d = rnd51(); scramble(d, s); data_in = s; tick();
      check_val("post_reset_data", 64'(data_out), 64'(d));
      check_val("post_reset_valid", 64'(data_valid), (n >= 1) ? 64'h1 : 64'h0);
    end

    // Bypass with random raw frames keeps the valid flag and passes data through.
    for (int n = 0; n < 4; n++) begin
      bypass = 1'b1; raw = rnd51(); data_in = raw; tick(); tx_push(raw);
      check_val("bypass_rand", 64'(data_out), 64'(raw));
    end
    bypass = 1'b0;
    d = rnd51(); scramble(d, s); data_in = s; tick();
    check_val("bypass_rand_exit", 64'(data_out), 64'(d));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
